// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock.
// Start/busy/done handshake; sum and cout are updated only on the completion edge.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc_sr;
  logic             carry;
  logic [CW-1:0]    count;

  logic             ha1_s;
  logic             ha1_c;
  logic             ha2_s;
  logic             ha2_c;
  logic             carry_next;
  logic [WIDTH-1:0] acc_next;

  // Full adder built from two half adders and an OR on the current LSBs.
  always_comb begin
    ha1_s      = a_sr[0] ^ b_sr[0];
    ha1_c      = a_sr[0] & b_sr[0];
    ha2_s      = ha1_s ^ carry;
    ha2_c      = ha1_s & carry;
    carry_next = ha1_c | ha2_c;
    acc_next   = {ha2_s, acc_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      acc_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            acc_sr <= '0;
            carry  <= cin;
            count  <= '0;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          acc_sr <= acc_next;
          carry  <= carry_next;
          count  <= count + 1'b1;
          // Last bit: publish the full result, never a partial one.
          if (count == LAST) begin
            sum   <= acc_next;
            cout  <= carry_next;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance for handshake/timing scenarios
// and a 4-bit instance for exhaustive arithmetic, both checked against a result queue.
module tb_serial_adder;

  logic       clk;
  logic       clk_en;
  logic       rst;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       cin4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;

  logic [8:0] exp_q8[$];
  logic [4:0] exp_q4[$];

  int n_checks;
  int n_fail;

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic test_reset();
    #3 rst = 1'b1;
    #2;
    n_checks++;
    if (busy8 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy8: got %b want 0", busy8); end
    n_checks++;
    if (done8 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done8: got %b want 0", done8); end
    n_checks++;
    if ({cout8, sum8} !== 9'h000) begin n_fail++; $display("[TB] FAIL reset_sum8: got %h want 000", {cout8, sum8}); end
    n_checks++;
    if ({busy4, done4, cout4, sum4} !== 7'h00) begin
      n_fail++; $display("[TB] FAIL reset_w4: got %h want 00", {busy4, done4, cout4, sum4});
    end
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL idle_after_reset: busy=%b done=%b want 0 0", busy8, done8);
    end
  endtask

  task automatic test_basic();
    logic [8:0] expv;
    int busy_cycles;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    exp_q8.push_back(9'h046);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'hFF; b8 = 8'hFF;
    busy_cycles = 0;
    while (busy8 === 1'b1 && busy_cycles < 20) begin
      busy_cycles++;
      n_checks++;
      if (done8 !== 1'b0 || {cout8, sum8} !== 9'h000) begin
        n_fail++; $display("[TB] FAIL basic_no_partial: done=%b sum=%h want 0 000", done8, {cout8, sum8});
      end
      @(negedge clk);
    end
    n_checks++;
    if (busy_cycles != 8) begin n_fail++; $display("[TB] FAIL basic_busy_len: got %0d want 8", busy_cycles); end
    n_checks++;
    if (done8 !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_done: got %b want 1", done8); end
    expv = exp_q8.pop_front();
    n_checks++;
    if ({cout8, sum8} !== expv) begin n_fail++; $display("[TB] FAIL basic_sum: got %h want %h", {cout8, sum8}, expv); end
    @(negedge clk);
    n_checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || {cout8, sum8} !== expv) begin
      n_fail++; $display("[TB] FAIL basic_hold: done=%b busy=%b sum=%h want 0 0 %h", done8, busy8, {cout8, sum8}, expv);
    end
  endtask

  task automatic test_carry();
    logic [8:0] expv;
    logic [7:0] av[2];
    logic [7:0] bv[2];
    logic       cv[2];
    int t;
    av[0] = 8'hFF; bv[0] = 8'h01; cv[0] = 1'b0;
    av[1] = 8'h5A; bv[1] = 8'hA5; cv[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a8 = av[i]; b8 = bv[i]; cin8 = cv[i]; start8 = 1'b1;
      exp_q8.push_back({1'b0, av[i]} + {1'b0, bv[i]} + {8'h00, cv[i]});
      @(negedge clk);
      start8 = 1'b0;
      t = 0;
      while (done8 !== 1'b1 && t < 30) begin @(negedge clk); t++; end
      n_checks++;
      if (done8 !== 1'b1) begin
        n_fail++; $display("[TB] FAIL carry_timeout_%0d: done=%b want 1", i, done8);
        void'(exp_q8.pop_front());
      end else begin
        expv = exp_q8.pop_front();
        n_checks++;
        if ({cout8, sum8} !== expv) begin
          n_fail++; $display("[TB] FAIL carry_sum_%0d: got %h want %h", i, {cout8, sum8}, expv);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] expv;
    int last_done;
    int n_done;
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    exp_q8.push_back(9'h010);
    last_done = -1;
    n_done = 0;
    for (int k = 0; k < 29; k++) begin
      @(negedge clk);
      if (k % 9 == 3) begin a8 = 8'hAA; b8 = 8'h77; cin8 = 1'b1; end
      if (k % 9 == 6) begin a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; end
      if (done8 === 1'b1) begin
        n_done++;
        expv = (exp_q8.size() > 0) ? exp_q8.pop_front() : 9'h1FF;
        n_checks++;
        if ({cout8, sum8} !== expv) begin
          n_fail++; $display("[TB] FAIL b2b_sum_%0d: got %h want %h", n_done, {cout8, sum8}, expv);
        end
        n_checks++;
        if (k - last_done != 9) begin
          n_fail++; $display("[TB] FAIL b2b_interval_%0d: got %0d want 9", n_done, k - last_done);
        end
        last_done = k;
        if (n_done < 3) exp_q8.push_back(9'h010);
        else start8 = 1'b0;
      end
    end
    n_checks++;
    if (n_done != 3) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d want 3", n_done); end
    n_checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_idle: busy=%b done=%b want 0 0", busy8, done8);
    end
    exp_q8.delete();
  endtask

  task automatic test_reset_mid_shift();
    logic [8:0] expv;
    int saw_done;
    int t;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #2;
    n_checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || {cout8, sum8} !== 9'h000) begin
      n_fail++; $display("[TB] FAIL midrst_clear: busy=%b done=%b sum=%h want 0 0 000", busy8, done8, {cout8, sum8});
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) saw_done++;
    end
    n_checks++;
    if (saw_done != 0) begin n_fail++; $display("[TB] FAIL midrst_no_done: active cycles=%0d want 0", saw_done); end
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    exp_q8.push_back(9'h002);
    @(negedge clk);
    start8 = 1'b0;
    t = 0;
    while (done8 !== 1'b1 && t < 30) begin @(negedge clk); t++; end
    expv = exp_q8.pop_front();
    n_checks++;
    if (done8 !== 1'b1 || {cout8, sum8} !== expv) begin
      n_fail++; $display("[TB] FAIL midrst_restart: done=%b sum=%h want 1 %h", done8, {cout8, sum8}, expv);
    end
    @(negedge clk);
  endtask

  task automatic test_exhaustive_w4();
    logic [4:0] expv;
    logic [8:0] v;
    int t;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; start4 = 1'b1;
      exp_q4.push_back({1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'h0, v[8]});
      @(negedge clk);
      start4 = 1'b0;
      a4 = ~v[3:0]; b4 = ~v[7:4];
      t = 0;
      while (done4 !== 1'b1 && t < 12) begin @(negedge clk); t++; end
      expv = exp_q4.pop_front();
      n_checks++;
      if (done4 !== 1'b1 || {cout4, sum4} !== expv) begin
        n_fail++;
        $display("[TB] FAIL w4_add a=%h b=%h cin=%b: done=%b sum=%h want 1 %h",
                 v[3:0], v[7:4], v[8], done4, {cout4, sum4}, expv);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk_en   = 1'b0;
    rst      = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_reset_mid_shift();
    test_exhaustive_w4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
